// File: rtl/pad_cfg_sequencer.sv
// pad_cfg_sequencer
//   Walks every user pad's configuration word out onto the pad control chain,
//   highest pad first and MSB first. It then pulses the chain load strobe and
//   turns on the per-pad high-voltage enables one at a time, with a fixed
//   stagger between pads. Power-good loss aborts the sequence and sets a
//   sticky error flag.
//
// Ports
//   wb_clk_i      in   sole clock, rising edge
//   wb_rst_i      in   synchronous active-high reset
//   start         in   single-cycle request; only honoured in IDLE with porb=1
//   porb          in   power good; low aborts any sequence in progress
//   cfg_idx       out  index of the pad whose word is requested
//   cfg_word      in   configuration word of pad cfg_idx (combinational lookup)
//   busy          out  sequence in progress
//   done          out  one-cycle pulse after a successful sequence
//   err           out  sticky abort flag, cleared by the next accepted start
//   serial_clock  out  chain shift clock
//   serial_load   out  chain load strobe
//   serial_data   out  chain shift data
//   pad_enh       out  per-pad high-voltage enable, bit k = pad k
module pad_cfg_sequencer #(
  parameter int unsigned NUM_PADS    = 38,
  parameter int unsigned CFG_BITS    = 13,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned ENH_STAGGER = 4,
  localparam int unsigned IDX_W      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                porb,
  output logic [IDX_W-1:0]    cfg_idx,
  input  logic [CFG_BITS-1:0] cfg_word,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data,
  output logic [NUM_PADS-1:0] pad_enh
);

  // Counter widths cover the largest legal parameter values.
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0]       BIT_LAST = 6'(CFG_BITS - 1);
  localparam logic [7:0]       STG_LAST = 8'(ENH_STAGGER - 1);
  localparam logic [6:0]       ENP_LAST = 7'(NUM_PADS - 1);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NUM_PADS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LOAD,
    S_ENABLE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]    r_idx;
  logic [CFG_BITS-1:0] r_shreg;
  logic [7:0]          r_div;    // cycles spent in the current half-period
  logic                r_phase;  // 0: serial_clock low half, 1: high half
  logic [5:0]          r_bit;    // bit position within the current word
  logic [7:0]          r_stg;    // cycles since the last pad enable
  logic [6:0]          r_enp;    // next pad to enable
  logic                r_done;
  logic                r_err;
  logic [NUM_PADS-1:0] r_pad_enh;

  logic                w_abort;
  logic                w_accept;
  logic                w_div_end;
  logic                w_bit_end;
  logic                w_word_end;
  logic                w_enh_tick;
  logic                w_enh_last;
  logic [NUM_PADS-1:0] w_enh_bit;

  assign w_abort    = !porb && (r_state != S_IDLE);
  assign w_accept   = (r_state == S_IDLE) && start && porb;
  assign w_div_end  = (r_div == DIV_LAST);
  assign w_bit_end  = w_div_end && r_phase;
  assign w_word_end = w_bit_end && (r_bit == BIT_LAST);
  assign w_enh_tick = (r_stg == STG_LAST);
  assign w_enh_last = w_enh_tick && (r_enp == ENP_LAST);
  assign w_enh_bit  = NUM_PADS'(1) << r_enp;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; power-good loss overrides every transition.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) w_next = S_FETCH;
        S_FETCH:  w_next = S_SHIFT;
        S_SHIFT:  if (w_word_end) w_next = (r_idx == '0) ? S_LOAD : S_FETCH;
        S_LOAD:   if (w_div_end) w_next = S_ENABLE;
        S_ENABLE: if (w_enh_last) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Output decode: serial lines are gated by state so they read 0 in the
  // cycle right after an abort without needing their own clear.
  always_comb begin
    busy         = 1'b0;
    serial_clock = 1'b0;
    serial_data  = 1'b0;
    serial_load  = 1'b0;
    case (r_state)
      S_FETCH:  busy = 1'b1;
      S_SHIFT: begin
        busy         = 1'b1;
        serial_clock = r_phase;
        serial_data  = r_shreg[CFG_BITS-1];
      end
      S_LOAD: begin
        busy        = 1'b1;
        serial_load = 1'b1;
      end
      S_ENABLE: busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word fetch, bit timing, pad index, enables and flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idx     <= '0;
      r_shreg   <= '0;
      r_div     <= '0;
      r_phase   <= 1'b0;
      r_bit     <= '0;
      r_stg     <= '0;
      r_enp     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pad_enh <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_err     <= 1'b1;
        r_pad_enh <= '0;
        r_div     <= '0;
        r_phase   <= 1'b0;
        r_bit     <= '0;
        r_stg     <= '0;
        r_enp     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!porb) begin
              r_pad_enh <= '0;
            end else if (start) begin
              r_pad_enh <= '0;
              r_err     <= 1'b0;
              r_idx     <= IDX_INIT;
            end
          end
          S_FETCH: begin
            r_shreg <= cfg_word;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
          end
          S_SHIFT: begin
            if (w_div_end) begin
              r_div   <= '0;
              r_phase <= !r_phase;
              // A bit ends after its high half; advance to the next bit then.
              if (r_phase) begin
                r_shreg <= r_shreg << 1;
                if (r_bit == BIT_LAST) begin
                  r_bit <= '0;
                  if (r_idx != '0) r_idx <= r_idx - 1'b1;
                end else begin
                  r_bit <= r_bit + 1'b1;
                end
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          S_LOAD: begin
            if (w_div_end) begin
              r_div <= '0;
              r_stg <= '0;
              r_enp <= '0;
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          S_ENABLE: begin
            if (w_enh_tick) begin
              r_stg     <= '0;
              r_pad_enh <= r_pad_enh | w_enh_bit;
              if (r_enp == ENP_LAST) begin
                r_enp  <= '0;
                r_done <= 1'b1;
              end else begin
                r_enp <= r_enp + 1'b1;
              end
            end else begin
              r_stg <= r_stg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg_idx = r_idx;
  assign done    = r_done;
  assign err     = r_err;
  assign pad_enh = r_pad_enh;

endmodule
